// File: rtl/stopwatch_counter.sv
// Counts 1-cycle millisecond ticks into BCD MM:SS.mmm under start/stop/clear/lap button control.
// Latency: one clock from a tick or button edge to the updated outputs. No backpressure; every tick in RUN is consumed.
module stopwatch_counter #(
    parameter bit SATURATE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ms_tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic [3:0] ms_h,
    output logic [3:0] ms_t,
    output logic [3:0] ms_o,
    output logic       running,
    output logic       hold,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Digit order, index 6 down to 0: min_t min_o sec_t sec_o ms_h ms_t ms_o
    localparam logic [6:0][3:0] DIG_MAX = {4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9, 4'd9};

    state_t          state;
    state_t          state_nxt;
    logic            start_q;
    logic            stop_q;
    logic            clear_q;
    logic            lap_q;
    logic            start_e;
    logic            stop_e;
    logic            clear_e;
    logic            lap_e;
    logic [6:0][3:0] cnt;
    logic [6:0][3:0] cnt_inc;
    logic [6:0][3:0] cnt_nxt;
    logic [6:0][3:0] snap;
    logic [6:0][3:0] snap_nxt;
    logic [6:0][3:0] disp;
    logic            carry;
    logic            at_max;
    logic            hold_nxt;
    logic            overflow_nxt;

    assign start_e = start & ~start_q;
    assign stop_e  = stop  & ~stop_q;
    assign clear_e = clear & ~clear_q;
    assign lap_e   = lap   & ~lap_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            clear_q <= 1'b0;
            lap_q   <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            clear_q <= clear;
            lap_q   <= lap;
        end
    end

    // Whole-count ripple in one cycle; carry surviving all digits means 99:59.999.
    always_comb begin
        carry   = 1'b1;
        cnt_inc = cnt;
        for (int i = 0; i < 7; i++) begin
            if (carry) begin
                if (cnt[i] >= DIG_MAX[i]) begin
                    cnt_inc[i] = 4'd0;
                end else begin
                    cnt_inc[i] = cnt[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
        at_max = carry;
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        snap_nxt     = snap;
        hold_nxt     = hold;
        overflow_nxt = overflow;
        if (clear_e) begin
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            snap_nxt     = '0;
            hold_nxt     = 1'b0;
            overflow_nxt = 1'b0;
        end else begin
            // Counting looks at the state before this edge's button commands.
            if (state == RUN && ms_tick) begin
                overflow_nxt = overflow | at_max;
                if (!(at_max && SATURATE)) begin
                    cnt_nxt = cnt_inc;
                end
            end
            case (state)
                IDLE, PAUSE: begin
                    if (start_e && !stop_e) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (ms_tick && at_max && SATURATE) begin
                        state_nxt = DONE;
                    end else if (stop_e) begin
                        state_nxt = PAUSE;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
            if (lap_e) begin
                if (hold) begin
                    hold_nxt = 1'b0;
                end else if (state == RUN) begin
                    hold_nxt = 1'b1;
                    snap_nxt = cnt_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            snap     <= '0;
            hold     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            snap     <= snap_nxt;
            hold     <= hold_nxt;
            overflow <= overflow_nxt;
        end
    end

    assign disp    = hold ? snap : cnt;
    assign min_t   = disp[6];
    assign min_o   = disp[5];
    assign sec_t   = disp[4];
    assign sec_o   = disp[3];
    assign ms_h    = disp[2];
    assign ms_t    = disp[1];
    assign ms_o    = disp[0];
    assign running = (state == RUN);

endmodule
